// File: rtl/ascii_rom_pkg.sv
// Shared constants, glyph address layout and arbiter state type
// for the ASCII glyph ROM arbiter.
package ascii_rom_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int CHAR_W = 7;
  localparam int ROW_W  = 4;
  localparam int CHAR_LSB = ROW_W;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // {char code, glyph row} -> ROM address
  function automatic logic [ADDR_W-1:0] glyph_addr(
    input logic [CHAR_W-1:0] ch,
    input logic [ROW_W-1:0]  row
  );
    return {ch, row};
  endfunction

endpackage

// File: rtl/ascii_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first request found
// searching upward from ptr_i+1, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] sel;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      sel = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascii_rom_arbiter.sv
// Shares the glyph ROM between text renderers, with lockable ownership.
// ASCII_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module ascii_rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ascii_rom_pkg::ADDR_W,
  parameter int DATA_W  = ascii_rom_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  import ascii_rom_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      gidx;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick, gnt_c, rsp_valid_q;

`ifdef ASCII_ARB_FIXED_PRIO_EN
  // lowest set bit wins
  always_comb begin
    pick = req & ((~req) + {{(NUM_REQ-1){1'b0}}, 1'b1});
  end
`else
  logic [PW-1:0] rr_q, rr_d;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (pick)
  );
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    gnt_c = '0;
    if (!reset) begin
      unique case (state_q)
        ARB:  gnt_c = pick;
        LOCK: gnt_c[owner_q] = req[owner_q];
        default: gnt_c = '0;
      endcase
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
`ifndef ASCII_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
    if (|gnt_c) rr_d = gidx;
`endif
    if (|gnt_c) addr_d = addr_arr[gidx];
    unique case (state_q)
      ARB: begin
        if (|gnt_c && req_lock[gidx]) begin
          state_d = LOCK;
          owner_d = gidx;
        end
      end
      LOCK: begin
        // owner still gets this cycle; release next
        if (!req_lock[owner_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      owner_q     <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
`ifndef ASCII_ARB_FIXED_PRIO_EN
      rr_q        <= PW'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rsp_valid_q <= gnt_c & req;
`ifndef ASCII_ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign gnt       = gnt_c;
  assign rom_addr  = addr_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_ascii_rom_arbiter.sv
// Self-checking bench for ascii_rom_arbiter with a ROM model and
// a cycle-level reference model of the arbitration rules.
module tb_ascii_rom_arbiter;

  import ascii_rom_pkg::*;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_lock, gnt, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, rsp_data;

  logic [DW-1:0] rom [2048];

  int n_vec = 0;
  int n_err = 0;

  bit            m_lock;
  int            m_owner, m_last;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  pend_v;
  logic [DW-1:0] pend_d;
  logic [N-1:0]  exp_gnt, exp_rv;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] exp_addr;

  ascii_rom_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic model_reset();
    m_lock  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_addr  = '0;
    pend_v  = '0;
    pend_d  = '0;
  endtask

  // drive one cycle, then compute what the DUT must show this cycle
  task automatic step(input logic rst, input logic [N-1:0] r,
                      input logic [N-1:0] l,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int g;
    logic [AW-1:0] av [N];
    @(posedge clk);
    #1;
    reset    = rst;
    req      = r;
    req_lock = l;
    req_addr = {a1, a0};
    av[0] = a0;
    av[1] = a1;
    @(negedge clk);
    exp_rv = pend_v;
    exp_rd = pend_d;
    g = -1;
    if (!rst) begin
      if (m_lock) begin
        if (r[m_owner]) g = m_owner;
      end else begin
`ifdef ASCII_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (r[i]) g = i;
`else
        for (int k = N; k >= 1; k--) if (r[(m_last + k) % N]) g = (m_last + k) % N;
`endif
      end
    end
    exp_gnt = (g >= 0) ? (N'(1) << g) : '0;
    if (g >= 0) m_addr = av[g];
    exp_addr = m_addr;
    if (rst) begin
      model_reset();
    end else begin
      pend_v = exp_gnt;
      if (g >= 0) begin
        pend_d = rom[av[g]];
        m_last = g;
      end
      if (m_lock) begin
        if (!l[m_owner]) m_lock = 1'b0;
      end else if (g >= 0 && l[g]) begin
        m_lock  = 1'b1;
        m_owner = g;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0, '0, '0);
    step(1'b1, 2'b11, 2'b11, 11'h123, 11'h456);
    n_vec++;
    if ({gnt, rsp_valid, rom_addr} !== {2'b00, 2'b00, 11'h000}) begin
      n_err++;
      $display("FAIL reset gnt/rv/addr got %h/%h/%h want 0/0/000", gnt, rsp_valid, rom_addr);
    end
  endtask

  task automatic test_single();
    step(1'b0, 2'b01, 2'b00, glyph_addr(7'h30, 4'h2), '0);
    n_vec++;
    if ({gnt, rom_addr} !== {exp_gnt, exp_addr} || gnt !== 2'b01) begin
      n_err++;
      $display("FAIL single_gnt got %h/%h want %h/%h", gnt, rom_addr, exp_gnt, exp_addr);
    end
    step(1'b0, 2'b00, 2'b00, '0, '0);
    n_vec++;
    if ({rsp_valid, rsp_data} !== {2'b01, 8'h38}) begin
      n_err++;
      $display("FAIL single_rsp got %h/%h want 01/38", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_alternate();
    step(1'b1, '0, '0, '0, '0);
    for (int c = 0; c < 7; c++) begin
      step(1'b0, (c < 6) ? 2'b11 : 2'b00, 2'b00, 11'h31A, 11'h45A);
      n_vec++;
      if ({gnt, rsp_valid, rom_addr} !== {exp_gnt, exp_rv, exp_addr}) begin
        n_err++;
        $display("FAIL alternate c%0d gnt/rv/addr got %h/%h/%h want %h/%h/%h",
                 c, gnt, rsp_valid, rom_addr, exp_gnt, exp_rv, exp_addr);
      end
      if (exp_rv != '0) begin
        n_vec++;
        if (rsp_data !== exp_rd) begin
          n_err++;
          $display("FAIL alternate_data c%0d got %h want %h", c, rsp_data, exp_rd);
        end
      end
    end
  endtask

  task automatic test_lock();
    int got1;
    got1 = 0;
    step(1'b1, '0, '0, '0, '0);
    for (int r = 0; r < 18; r++) begin
      step(1'b0, (r == 0) ? 2'b10 : (r < 16) ? 2'b11 : 2'b01,
           (r < 15) ? 2'b10 : 2'b00, 11'h31A, 11'h430 + 11'(r));
      if (rsp_valid === 2'b10) got1++;
      n_vec++;
      if ({gnt, rsp_valid, rom_addr} !== {exp_gnt, exp_rv, exp_addr}) begin
        n_err++;
        $display("FAIL lock r%0d gnt/rv/addr got %h/%h/%h want %h/%h/%h",
                 r, gnt, rsp_valid, rom_addr, exp_gnt, exp_rv, exp_addr);
      end
      if (exp_rv != '0) begin
        n_vec++;
        if (rsp_data !== exp_rd) begin
          n_err++;
          $display("FAIL lock_data r%0d got %h want %h", r, rsp_data, exp_rd);
        end
      end
      if (r == 3) begin
        n_vec++;
        if (rsp_data !== 8'h7C) begin
          n_err++;
          $display("FAIL lock_row432 got %h want 7c", rsp_data);
        end
      end
    end
    n_vec++;
    if (got1 != 16) begin
      n_err++;
      $display("FAIL lock_count got %0d want 16", got1);
    end
  endtask

  task automatic test_reset_in_lock();
    step(1'b1, '0, '0, '0, '0);
    step(1'b0, 2'b10, 2'b10, '0, 11'h430);
    step(1'b0, 2'b10, 2'b10, '0, 11'h431);
    step(1'b1, 2'b10, 2'b10, '0, 11'h432);
    step(1'b0, 2'b11, 2'b00, 11'h31A, 11'h433);
    n_vec++;
    if ({gnt, rsp_valid} !== {exp_gnt, exp_rv} || {gnt, rsp_valid} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_in_lock gnt/rv got %h/%h want %h/%h", gnt, rsp_valid, exp_gnt, exp_rv);
    end
  endtask

  task automatic test_stall();
    step(1'b1, '0, '0, '0, '0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, (c == 0) ? 2'b10 : (c < 4) ? 2'b01 : (c == 4) ? 2'b10 : 2'b01,
           (c < 4) ? 2'b10 : 2'b00, 11'h111, 11'h222);
      n_vec++;
      if ({gnt, rsp_valid, rom_addr} !== {exp_gnt, exp_rv, exp_addr}) begin
        n_err++;
        $display("FAIL stall c%0d gnt/rv/addr got %h/%h/%h want %h/%h/%h",
                 c, gnt, rsp_valid, rom_addr, exp_gnt, exp_rv, exp_addr);
      end
    end
  endtask

  task automatic test_unmapped();
    step(1'b0, 2'b01, 2'b00, 11'h000, 11'h7FF);
    step(1'b0, 2'b00, 2'b00, 11'h000, 11'h7FF);
    n_vec++;
    if ({rsp_valid, rom_addr} !== {exp_rv, exp_addr} || rsp_valid !== 2'b01) begin
      n_err++;
      $display("FAIL unmapped rv/addr got %h/%h want %h/%h", rsp_valid, rom_addr, exp_rv, exp_addr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 49) == 0), N'($urandom), N'($urandom),
           AW'($urandom), AW'($urandom));
      n_vec++;
      if ({gnt, rsp_valid, rom_addr} !== {exp_gnt, exp_rv, exp_addr}) begin
        n_err++;
        $display("FAIL random c%0d gnt/rv/addr got %h/%h/%h want %h/%h/%h",
                 c, gnt, rsp_valid, rom_addr, exp_gnt, exp_rv, exp_addr);
      end
      if (exp_rv != '0) begin
        n_vec++;
        if (rsp_data !== exp_rd) begin
          n_err++;
          $display("FAIL random_data c%0d got %h want %h", c, rsp_data, exp_rd);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = DW'((a * 37) ^ (a >> 5));
    rom[11'h302] = 8'h38;
    rom[11'h31A] = 8'h7E;
    rom[11'h45A] = 8'hFE;
    rom[11'h432] = 8'h7C;
    reset    = 1'b1;
    req      = '0;
    req_lock = '0;
    req_addr = '0;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_reset_in_lock();
    test_stall();
    test_unmapped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
